// File: rtl/fp_div_iter_if.sv
// Operand/result handshake bundle for the iterative FP divider.
// master = operand issuer and result consumer, slave = the divider.
interface fp_div_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [4:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, flags
    );
endinterface

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider: restoring radix-2 quotient loop, RNE rounding,
// flush-to-zero on denormal inputs and underflow, one operation in flight.
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    fp_div_iter_if.slave  io
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int Q     = MAN_W + 3;
    localparam int CNT_W = $clog2(Q);
    localparam int EW    = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, DONE} state_e;

    state_e                  state_q;
    logic [W-1:0]            a_q, b_q;
    logic                    sign_q;
    logic signed [EW-1:0]    exp_q;
    logic [MAN_W:0]          mb_q;
    logic [MAN_W+1:0]        rem_q;
    logic [Q-1:0]            quo_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    in_ready_q, out_valid_q;
    logic [W-1:0]            res_q;
    logic [4:0]              flags_q;

    // Operand decode
    logic                 sa, sb, sign_d;
    logic [EXP_W-1:0]     ea, eb;
    logic [MAN_W-1:0]     fa, fb;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic signed [EW-1:0] exp_un_d;

    assign sa     = a_q[W-1];
    assign sb     = b_q[W-1];
    assign ea     = a_q[W-2:MAN_W];
    assign eb     = b_q[W-2:MAN_W];
    assign fa     = a_q[MAN_W-1:0];
    assign fb     = b_q[MAN_W-1:0];
    assign sign_d = sa ^ sb;
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_inf  = (&ea) & ~|fa;
    assign b_inf  = (&eb) & ~|fb;
    assign a_nan  = (&ea) & |fa;
    assign b_nan  = (&eb) & |fb;
    assign exp_un_d = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;

    logic         spec_d;
    logic [W-1:0] spec_res_d;
    logic [4:0]   spec_flags_d;

    always_comb begin
        spec_d       = 1'b1;
        spec_res_d   = '0;
        spec_flags_d = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res_d   = QNAN;
            spec_flags_d = 5'b10000;
        end else if (a_inf) begin
            spec_res_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res_d = {sign_d, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_res_d   = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags_d = 5'b01000;
        end else if (a_zero) begin
            spec_res_d = {sign_d, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    // Restoring step; rem stays below 2*mb, so the shifted value fits MAN_W+2 bits
    logic             ge_d;
    logic [MAN_W+1:0] rem_sub_d, rem_d;
    logic [Q-1:0]     quo_d;

    always_comb begin
        ge_d      = rem_q >= {1'b0, mb_q};
        rem_sub_d = ge_d ? rem_q - {1'b0, mb_q} : rem_q;
        rem_d     = {rem_sub_d[MAN_W:0], 1'b0};
        quo_d     = {quo_q[Q-2:0], ge_d};
    end

    // Normalise, round to nearest even, range check
    logic [Q-1:0]         norm_d;
    logic signed [EW-1:0] exp_n_d, exp_r_d;
    logic [MAN_W:0]       mant_d;
    logic [MAN_W+1:0]     mant_r_d;
    logic [MAN_W-1:0]     frac_d;
    logic                 g_d, r_d, s_d, up_d, carry_d, inx_d;
    logic [W-1:0]         rnd_res_d;
    logic [4:0]           rnd_flags_d;

    always_comb begin
        norm_d   = quo_q[Q-1] ? quo_q : {quo_q[Q-2:0], 1'b0};
        exp_n_d  = quo_q[Q-1] ? exp_q : exp_q - EW'(1);
        mant_d   = norm_d[Q-1:2];
        g_d      = norm_d[1];
        r_d      = norm_d[0];
        s_d      = |rem_q;
        up_d     = g_d & (r_d | s_d | mant_d[0]);
        mant_r_d = {1'b0, mant_d} + (MAN_W+2)'(up_d);
        carry_d  = mant_r_d[MAN_W+1];
        frac_d   = carry_d ? mant_r_d[MAN_W:1] : mant_r_d[MAN_W-1:0];
        exp_r_d  = exp_n_d + EW'(carry_d);
        inx_d    = g_d | r_d | s_d;
        if (exp_r_d >= EMAX_E) begin
            rnd_res_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags_d = 5'b00101;
        end else if (exp_r_d[EW-1] || exp_r_d == '0) begin
            rnd_res_d   = {sign_q, {(W-1){1'b0}}};
            rnd_flags_d = 5'b00011;
        end else begin
            rnd_res_d   = {sign_q, exp_r_d[EXP_W-1:0], frac_d};
            rnd_flags_d = {4'b0000, inx_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mb_q        <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid && in_ready_q) begin
                        a_q        <= io.a;
                        b_q        <= io.b;
                        in_ready_q <= 1'b0;
                        state_q    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q <= sign_d;
                    if (spec_d) begin
                        res_q       <= spec_res_d;
                        flags_q     <= spec_flags_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        exp_q   <= exp_un_d;
                        rem_q   <= {2'b01, fa};
                        mb_q    <= {1'b1, fb};
                        quo_q   <= '0;
                        cnt_q   <= CNT_W'(Q - 1);
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) state_q <= ROUND;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                ROUND: begin
                    res_q       <= rnd_res_d;
                    flags_q     <= rnd_flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.res       = res_q;
    assign io.flags     = flags_q;
endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter: driver pushes model results, monitor pops on out_valid.
module tb_fp_div_iter;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          lat;
        int          acc;
        int          hold;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    sb_item_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_div_iter_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
    fp_div_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .rst(rst), .io(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: exact integer division of the significands, then RNE on the scaled quotient
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f, output int lat);
        logic s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic an, bn, ai, bi, az, bz, g, st;
        longint ma, mb, q, rm, mant;
        int e, sh;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        an = (ea == 8'hFF) && (fa != 0);
        bn = (eb == 8'hFF) && (fb != 0);
        ai = (ea == 8'hFF) && (fa == 0);
        bi = (eb == 8'hFF) && (fb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        lat = 2;
        f = 5'b0;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = 32'h7FC00000; f = 5'b10000;
        end else if (ai) begin
            r = {s, 8'hFF, 23'h0};
        end else if (bi) begin
            r = {s, 31'h0};
        end else if (bz) begin
            r = {s, 8'hFF, 23'h0}; f = 5'b01000;
        end else if (az) begin
            r = {s, 31'h0};
        end else begin
            lat = MAN_W + 6;
            ma = longint'({1'b1, fa});
            mb = longint'({1'b1, fb});
            e  = int'(ea) - int'(eb) + 127;
            sh = (ma >= mb) ? 24 : 25;
            if (ma < mb) e--;
            q    = (ma << sh) / mb;
            rm   = (ma << sh) % mb;
            mant = q >> 1;
            g    = (q & 1) != 0;
            st   = rm != 0;
            if (g && (st || (mant & 1) != 0)) mant++;
            if (mant == (longint'(1) << 24)) begin
                mant = mant >> 1;
                e++;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0}; f = 5'b00101;
            end else if (e <= 0) begin
                r = {s, 31'h0}; f = 5'b00011;
            end else begin
                r = {s, 8'(e), 23'(mant)}; f = {4'b0, g | st};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic s;
        int k;
        s = 1'($urandom);
        k = $urandom_range(0, 11);
        case (k)
            0:       return {s, 8'h00, (($urandom & 1) != 0) ? 23'($urandom) : 23'h0};
            1:       return {s, 8'hFF, 23'h0};
            2:       return {s, 8'hFF, 23'($urandom) | 23'h1};
            default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input int hold);
        sb_item_t it;
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0, required 1 within 200 cycles");
            return;
        end
        model(a, b, it.res, it.flags, it.lat);
        it.acc  = cyc;
        it.hold = hold;
        sbq.push_back(it);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: latency on first valid, stability under backpressure, value on handshake
    initial begin
        sb_item_t e;
        logic seen, took, bp;
        int cnt;
        seen = 1'b0; took = 1'b0; bp = 1'b0; cnt = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (took) begin
                bus.out_ready = 1'b0;
                took = 1'b0;
                if (bp) chk("in_ready_after_take", 64'(bus.in_ready), 64'd1);
            end
            if (rst) begin
                seen = 1'b0;
            end else if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_out_valid: got out_valid=1 res=%h, required no result", bus.res);
                end else begin
                    e = sbq[0];
                    if (!seen) begin
                        seen = 1'b1;
                        cnt = e.hold;
                        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    end
                    if (cnt == 0) begin
                        bus.out_ready = 1'b1;
                        chk("res", 64'(bus.res), 64'(e.res));
                        chk("flags", 64'(bus.flags), 64'(e.flags));
                        void'(sbq.pop_front());
                        seen = 1'b0;
                        took = 1'b1;
                        bp = e.hold > 0;
                    end else begin
                        chk("hold_res", 64'(bus.res), 64'(e.res));
                        chk("hold_flags", 64'(bus.flags), 64'(e.flags));
                        chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        logic saw;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res", 64'(bus.res), 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h40C00000, 32'h40000000, 0);
        issue(32'h3F800000, 32'h40400000, 1);
        issue(32'hBF800000, 32'h00000000, 0);
        issue(32'h00000000, 32'h00000000, 2);
        issue(32'h7F000000, 32'h3E800000, 0);
        issue(32'h00800000, 32'h7E800000, 0);
        issue(32'h7F800000, 32'hC0000000, 0);
        issue(32'h3F800000, 32'hFF800000, 0);
        issue(32'h00400000, 32'h3F800000, 0);
        issue(32'h40400000, 32'h3F000000, 5);
        issue(32'h3FC00000, 32'h40200000, 0);
        drain();

        for (int i = 0; i < 40; i++) issue(rnd_op(), rnd_op(), $urandom_range(0, 3));
        drain();

        // Reset in the middle of the quotient loop discards the operation
        issue(32'h3F800000, 32'h40400000, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
        saw = 1'b0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            saw = saw | bus.out_valid;
        end
        chk("no_result_after_rst", 64'(saw), 64'd0);
        issue(32'h40000000, 32'h3F000000, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Parametrised, iterative IEEE-754 floating-point divider; sequential successor to the combinational single-precision divide path in the FPU.
- Generic exponent and mantissa widths, restoring radix-2 quotient loop.
- Round-to-nearest-even, full special-case handling, exception flags.
- Valid/ready handshake on both sides; sits between the FPU operand issue stage and the result writeback.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).
- Derived values, not overridable:
  - W = 1+EXP_W+MAN_W
  - BIAS = 2^(EXP_W-1)-1
  - Q = MAN_W+3 (number of quotient bits)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept operands
- a  in  W  dividend, IEEE format
- b  in  W  divisor, IEEE format
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- res  out  W  quotient, IEEE format
- flags  out  5  {invalid, divzero, overflow, underflow, inexact}

Behaviour:
- Reset: one clk with rst=1 forces state IDLE, in_ready=1, out_valid=0, res=0, flags=0, and clears all internal registers.
  - Reset overrides any handshake in the same cycle.
  - Reset mid-operation discards the operation; no result is produced.
- FSM states: IDLE, UNPACK, DIVIDE, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a/b, go to UNPACK.
  - UNPACK: split sign, exponent and fraction. Exponent 0 (denormal or zero) is treated as zero (flush-to-zero). Set hidden bit for normals.
    - If a special case applies: form the result, go to DONE.
    - Otherwise: exp_t = ea-eb+BIAS (signed, EXP_W+2 bits); remainder = mant_a; go to DIVIDE.
  - DIVIDE: one quotient bit per cycle for Q cycles (counter Q-1 down to 0). Restoring step: if rem>=mant_b then bit=1 and rem=rem-mant_b; then rem<<=1. Exit to ROUND after the last bit.
  - ROUND:
    - Normalise: if quotient MSB=0, shift left 1 and decrement exp_t.
    - sticky = OR of remainder bits; apply RNE using guard, round and sticky bits.
    - If rounding carries out of the mantissa, shift right and increment exp_t.
    - exp_t >= 2^EXP_W-1: result is signed infinity; set overflow and inexact.
    - exp_t <= 0: result is signed zero; set underflow and inexact.
    - inexact = guard|round|sticky. Go to DONE.
  - DONE: out_valid=1; res and flags held stable. On out_ready, go to IDLE and drop out_valid.
- in_ready is 0 in every state except IDLE; there is no overlap of operations.
- Latency, counting from the accept edge T:
  - Normal operands: out_valid rises at T+Q+3 (T+29 at defaults).
  - Special cases: out_valid rises at T+2.
- Sign of every result, including zero and infinity, is sa^sb. Canonical NaN is the exception: sign 0, exponent all ones, fraction MSB set, other bits 0.
- Special-case priority (highest first):
  1. Either operand NaN, 0/0, or inf/inf: canonical NaN, invalid=1.
  2. inf/x: infinity.
  3. x/inf: zero.
  4. Nonzero finite / 0: infinity, divzero=1.
  5. 0/x: zero.
- Special-case results have all flags 0 except those stated above.
- Input changes while busy are ignored. A result not taken by the consumer stalls the unit indefinitely, with no data loss.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000, out_ready=1 -> res=0x40400000, flags=0, out_valid exactly 29 cycles after accept.
- a=0x3F800000, b=0x40400000 (1/3) -> res=0x3EAAAAAB (RNE round-up), flags=00001.
- a=0xBF800000, b=0x00000000 -> res=0xFF800000, flags=01000, latency 2. Then a=0, b=0 -> res=0x7FC00000, flags=10000.
- a=0x7F000000, b=0x3E800000 -> res=0x7F800000, flags=00101. Then a=0x00800000, b=0x7E800000 -> res=0x00000000, flags=00011.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> res/flags stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 next cycle; back-to-back second divide is correct.
- Assert rst for 1 cycle at DIVIDE cycle 10 -> out_valid never asserts for that operation, in_ready=1 the cycle after reset. A new divide 2.0/0.5 -> 0x40800000.
